// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide HI/LO unit.
package md_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/md_div_core.sv
// Restoring unsigned divider, one quotient bit per step.
// Load performs the first iteration, so WIDTH-1 steps complete the divide.
module md_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] remR;
  logic [WIDTH-1:0] quoR;
  logic [WIDTH-1:0] divR;

  // One restoring iteration: shift in the next dividend bit, subtract if it fits.
  function automatic logic [2*WIDTH-1:0] iterate(input logic [WIDTH-1:0] rem,
                                                 input logic [WIDTH-1:0] quo,
                                                 input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    if (shifted >= {1'b0, dvs}) begin
      iterate = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    end else begin
      iterate = {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remR <= '0;
      quoR <= '0;
      divR <= '0;
    end else if (load) begin
      {remR, quoR} <= iterate('0, dividend, divisor);
      divR         <= divisor;
    end else if (step) begin
      {remR, quoR} <= iterate(remR, quoR, divR);
    end
  end

  assign quotient  = quoR;
  assign remainder = remR;

endmodule

// File: rtl/md_hilo_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing a {HI,LO} pair for the E->M handoff.
module md_hilo_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH      = MD_WIDTH,
  parameter int unsigned MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  md_state_e        state;
  md_state_e        stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             startOp;
  logic             stepDiv;
  logic             finish;
  logic             stallC;

  md_op_e           opR;
  logic [WIDTH-1:0] aR;
  logic [WIDTH-1:0] bR;

  logic             signedInE;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  logic [2*WIDTH-1:0] extA;
  logic [2*WIDTH-1:0] extB;
  logic [2*WIDTH-1:0] product;
  logic               negQ;
  logic               negR;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next state and control decode
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    startOp   = 1'b0;
    stepDiv   = 1'b0;
    finish    = 1'b0;
    stallC    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (startE && !cancel) begin
          startOp   = 1'b1;
          stallC    = 1'b1;
          cntNext   = '0;
          stateNext = opE[1] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        stallC = 1'b1;
        if (cancel) begin
          stateNext = ST_IDLE;
        end else if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
          finish    = 1'b1;
          stateNext = ST_DONE;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      ST_DIV: begin
        stallC = 1'b1;
        if (cancel) begin
          stateNext = ST_IDLE;
        end else if (cnt == CNT_W'(WIDTH - 1)) begin
          finish    = 1'b1;
          stateNext = ST_DONE;
        end else begin
          stepDiv = 1'b1;
          cntNext = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign stall = stallC;
  assign done  = (state == ST_DONE);

  // Divider sees magnitudes straight from E so it can load on the start edge
  always_comb begin
    signedInE = (opE == MD_DIV);
    magA      = (signedInE && srcaE[WIDTH-1]) ? (WIDTH'(0) - srcaE) : srcaE;
    magB      = (signedInE && srcbE[WIDTH-1]) ? (WIDTH'(0) - srcbE) : srcbE;
  end

  md_div_core #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (startOp && opE[1]),
    .step     (stepDiv),
    .dividend (magA),
    .divisor  (magB),
    .quotient (quotient),
    .remainder(remainder)
  );

  always_comb begin
    extA    = (opR == MD_MULT) ? {{WIDTH{aR[WIDTH-1]}}, aR} : {{WIDTH{1'b0}}, aR};
    extB    = (opR == MD_MULT) ? {{WIDTH{bR[WIDTH-1]}}, bR} : {{WIDTH{1'b0}}, bR};
    product = extA * extB;
    negQ    = (opR == MD_DIV) && (aR[WIDTH-1] ^ bR[WIDTH-1]);
    negR    = (opR == MD_DIV) && aR[WIDTH-1];
  end

  // Operand latch and result registers; results change only on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opR  <= MD_MULT;
      aR   <= '0;
      bR   <= '0;
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      if (startOp) begin
        opR <= md_op_e'(opE);
        aR  <= srcaE;
        bR  <= srcbE;
      end
      if (finish) begin
        if (!opR[1]) begin
          hi_o <= product[2*WIDTH-1:WIDTH];
          lo_o <= product[WIDTH-1:0];
        end else if (bR == '0) begin
          hi_o <= aR;
          lo_o <= '1;
        end else begin
          hi_o <= negR ? (WIDTH'(0) - remainder) : remainder;
          lo_o <= negQ ? (WIDTH'(0) - quotient) : quotient;
        end
      end
    end
  end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Directed bench for md_hilo_unit: latency, results, cancel and async reset.
module tb_md_hilo_unit;

  logic        clk;
  logic        rst;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        cancel;
  logic        stall;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int testCount;
  int failCount;

  md_hilo_unit dut (
    .clk   (clk),
    .rst   (rst),
    .startE(startE),
    .opE   (opE),
    .srcaE (srcaE),
    .srcbE (srcbE),
    .cancel(cancel),
    .stall (stall),
    .done  (done),
    .hi_o  (hi_o),
    .lo_o  (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Count stall cycles from the current cycle, then check the DONE cycle.
  task automatic waitCheck(input string tag, input int expStall,
                           input logic [31:0] expHi, input logic [31:0] expLo);
    int n;
    n = 0;
    #1;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    checkVal({tag, ".stall"}, 64'(n), 64'(expStall));
    checkVal({tag, ".done"}, 64'(done), 64'd1);
    checkVal({tag, ".hi"}, 64'(hi_o), 64'(expHi));
    checkVal({tag, ".lo"}, 64'(lo_o), 64'(expLo));
  endtask

  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input int expStall,
                       input logic [31:0] expHi, input logic [31:0] expLo);
    @(negedge clk);
    startE = 1'b1;
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    waitCheck(tag, expStall, expHi, expLo);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    startE = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int doneSeen;
    testCount = 0;
    failCount = 0;
    rst    = 1'b1;
    startE = 1'b0;
    opE    = 2'b00;
    srcaE  = '0;
    srcbE  = '0;
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkVal("reset.hi", 64'(hi_o), 64'd0);
    checkVal("reset.lo", 64'(lo_o), 64'd0);
    checkVal("reset.done", 64'(done), 64'd0);
    checkVal("reset.stall", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    runOp("mult", 2'b00, 32'hFFFFFFFF, 32'h00000002, 3, 32'hFFFFFFFF, 32'hFFFFFFFE);
    idle(1);
    runOp("multu", 2'b01, 32'hFFFFFFFF, 32'h00000002, 3, 32'h00000001, 32'hFFFFFFFE);
    runOp("multuB2B", 2'b01, 32'h00010000, 32'h00010000, 3, 32'h00000001, 32'h00000000);
    runOp("multNegNeg", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 3, 32'h00000000, 32'h00000006);
    idle(1);

    runOp("divNeg7", 2'b10, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runOp("divMinNeg1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
    runOp("div7Neg2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
    runOp("divu100by7", 2'b11, 32'h00000064, 32'h00000007, 33, 32'h00000002, 32'h0000000E);
    runOp("divuByZero", 2'b11, 32'h12345678, 32'h00000000, 33, 32'h12345678, 32'hFFFFFFFF);
    idle(1);

    // Cancel partway through a divide
    @(negedge clk);
    startE = 1'b1;
    opE    = 2'b10;
    srcaE  = 32'h00000064;
    srcbE  = 32'h00000003;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    checkVal("cancel.stallHeld", 64'(stall), 64'd1);
    @(negedge clk);
    cancel = 1'b0;
    startE = 1'b0;
    #1;
    checkVal("cancel.stallDrop", 64'(stall), 64'd0);
    checkVal("cancel.hiKept", 64'(hi_o), 64'h12345678);
    checkVal("cancel.loKept", 64'(lo_o), 64'hFFFFFFFF);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkVal("cancel.noDone", 64'(doneSeen), 64'd0);
    runOp("divu9by3", 2'b11, 32'h00000009, 32'h00000003, 33, 32'h00000000, 32'h00000003);
    idle(1);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    startE = 1'b1;
    opE    = 2'b10;
    srcaE  = 32'hFFFFFFF9;
    srcbE  = 32'h00000002;
    repeat (5) @(negedge clk);
    #3;
    rst   = 1'b1;
    opE   = 2'b01;
    srcaE = 32'h00000003;
    srcbE = 32'h00000005;
    #1;
    checkVal("rst.hi", 64'(hi_o), 64'd0);
    checkVal("rst.lo", 64'(lo_o), 64'd0);
    checkVal("rst.done", 64'(done), 64'd0);
    checkVal("rst.idleStall", 64'(stall), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    waitCheck("rstRestart", 3, 32'h00000000, 32'h0000000F);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
